// File: rtl/pn_pkg.sv
// Shared definitions for the pseudo-noise generator: primitive tap masks,
// default seeds and a width-generic Fibonacci LFSR step function.
package pn_pkg;

    // Feedback masks: bit i set means state[i] joins the XOR.
    localparam logic [31:0] PN7_TAPS  = 32'h0000_0060;
    localparam logic [31:0] PN9_TAPS  = 32'h0000_0110;
    localparam logic [31:0] PN15_TAPS = 32'h0000_6000;
    localparam logic [31:0] PN23_TAPS = 32'h0042_0000;
    localparam logic [31:0] PN31_TAPS = 32'h4800_0000;

    localparam logic [31:0] PN7_SEED  = 32'h0000_007F;
    localparam logic [31:0] PN9_SEED  = 32'h0000_01FF;
    localparam logic [31:0] PN15_SEED = 32'h0000_3BBB;
    localparam logic [31:0] PN23_SEED = 32'h007F_FFFF;
    localparam logic [31:0] PN31_SEED = 32'h7FFF_FFFF;

    // One Fibonacci step: shift left, feedback into bit 0, masked to width.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] state,
        input logic [31:0] taps,
        input int unsigned width
    );
        logic        fb;
        logic [31:0] mask;
        fb   = ^(state & taps);
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        return {state[30:0], fb} & mask;
    endfunction

endpackage

// File: rtl/pn_lfsr_core.sv
// LFSR state register with seed load, zero-state recovery and period counter.
// Ports: clk_i/rst_i clock and async active-high reset; shift_i advances one
// bit; load_i/seed_i reload the state (zero seed -> SEED, seed_err_o pulse);
// out_bit_o is the bit leaving the MSB; wrap_o flags the last shift of a
// period; guard_o is high while the state is all-zero and being recovered.
module pn_lfsr_core import pn_pkg::*; #(
    parameter int unsigned       WIDTH = 15,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(PN15_TAPS),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(PN15_SEED)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic             out_bit_o,
    output logic             wrap_o,
    output logic             guard_o,
    output logic             seed_err_o
);

    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] next_w;
    logic             err_q, err_d;
    logic             wrap;
    logic             seed_zero;

    assign next_w    = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), WIDTH));
    assign seed_zero = (seed_i == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wrap    = 1'b0;
        if (load_i) begin
            state_d = seed_zero ? SEED : seed_i;
            err_d   = seed_zero;
            cnt_d   = '0;
        end else if (state_q == '0) begin
            // Only reachable with non-primitive taps: escape lock-up.
            state_d = SEED;
            cnt_d   = '0;
        end else if (shift_i) begin
            state_d = next_w;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SEED;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign out_bit_o  = state_q[WIDTH-1];
    assign wrap_o     = wrap;
    assign guard_o    = (state_q == '0);
    assign seed_err_o = err_q;

endmodule

// File: rtl/pn_seq_gen.sv
// Pseudo-noise symbol source: LFSR bits packed MSB-first into SYM_BITS-wide
// symbols with a valid/ready output and a sequence-start marker.
// Ports: clk, rst (async, active-high); en gates generation; seed_load with
// seed_in restarts the sequence; sym_ready/sym_valid/sym_data form the output
// handshake; seq_start marks the symbol holding the first bit of a period;
// seed_err pulses when a zero seed was replaced by SEED.
module pn_seq_gen import pn_pkg::*; #(
    parameter int unsigned       WIDTH    = 15,
    parameter logic [WIDTH-1:0]  TAPS     = WIDTH'(PN15_TAPS),
    parameter logic [WIDTH-1:0]  SEED     = WIDTH'(PN15_SEED),
    parameter int unsigned       SYM_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                sym_ready,
    output logic                sym_valid,
    output logic [SYM_BITS-1:0] sym_data,
    output logic                seq_start,
    output logic                seed_err
);

    localparam int unsigned     CW   = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
    localparam logic [CW-1:0]   LAST = CW'(SYM_BITS - 1);

    logic                out_bit;
    logic                wrap;
    logic                guard;
    logic                stall;
    logic                shift;
    logic                hit_first;
    logic [SYM_BITS-1:0] sh_next;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SYM_BITS-1:0] shreg_q, shreg_d;
    logic [SYM_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                start_q, start_d;
    logic                first_q, first_d;
    logic                acc_q, acc_d;

    // A held symbol blocks the LFSR so no bit is ever dropped.
    assign stall = valid_q && !sym_ready;
    assign shift = en && !seed_load && !stall && !guard;

    pn_lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk_i      (clk),
        .rst_i      (rst),
        .shift_i    (shift),
        .load_i     (seed_load),
        .seed_i     (seed_in),
        .out_bit_o  (out_bit),
        .wrap_o     (wrap),
        .guard_o    (guard),
        .seed_err_o (seed_err)
    );

    // Truncating cast keeps the low SYM_BITS bits, so width 1 degenerates
    // to the current bit alone.
    assign sh_next   = SYM_BITS'({shreg_q, out_bit});
    assign hit_first = acc_q | first_q;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        start_d = start_q;
        first_d = first_q;
        acc_d   = acc_q;
        if (valid_q && sym_ready) begin
            valid_d = 1'b0;
        end
        if (seed_load) begin
            cnt_d   = '0;
            acc_d   = 1'b0;
            first_d = 1'b1;
            valid_d = 1'b0;
        end else if (shift) begin
            if (cnt_q == LAST) begin
                data_d  = sh_next;
                start_d = hit_first;
                valid_d = 1'b1;
                cnt_d   = '0;
                acc_d   = 1'b0;
            end else begin
                shreg_d = sh_next;
                cnt_d   = cnt_q + CW'(1);
                acc_d   = hit_first;
            end
            // The bit after a period wrap opens the next period.
            first_d = wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            first_q <= 1'b1;
            acc_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            first_q <= first_d;
            acc_q   <= acc_d;
        end
    end

    assign sym_valid = valid_q;
    assign sym_data  = data_q;
    assign seq_start = start_q;

endmodule
